// File: rtl/checker_somador_subtrator.sv
// checker_somador_subtrator: response monitor for a WIDTH-bit adder/subtractor.
// Recomputes the golden result, keeps saturating pass/fail counts and captures the first failure.
`default_nettype none

module checker_somador_subtrator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 sub,
    input  logic [WIDTH-1:0]     Result,
    input  logic                 C_out,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 err_sticky,
    output logic [4*WIDTH+2:0]   fail_info
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_OK   = 1'b0,
        S_FAIL = 1'b1
    } state_t;

    state_t state;

    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   golden;

    logic             s1_valid;
    logic             s1_sub;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_r;
    logic             s1_c;
    logic [WIDTH:0]   s1_exp;
    logic             s1_bad;

    // Ready drops while reset is held and during the clear cycle, so those samples are dropped.
    assign in_ready = ~rst & ~clear;
    assign accept   = in_valid & in_ready;

    // Subtraction is A + ~B + 1, so the carry out means "no borrow".
    always_comb begin
        b_eff  = sub ? ~B : B;
        golden = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sub   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_r     <= '0;
            s1_c     <= 1'b0;
            s1_exp   <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sub <= sub;
                s1_a   <= A;
                s1_b   <= B;
                s1_r   <= Result;
                s1_c   <= C_out;
                s1_exp <= golden;
            end
        end
    end

    // Case inequality makes unknown DUT outputs count as failures in simulation.
    assign s1_bad = ({s1_c, s1_r} !== s1_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_OK;
            mismatch   <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_sticky <= 1'b0;
            fail_info  <= '0;
        end else if (clear) begin
            state      <= S_OK;
            mismatch   <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_sticky <= 1'b0;
            fail_info  <= '0;
        end else begin
            mismatch <= 1'b0;
            if (s1_valid) begin
                if (s1_bad) begin
                    mismatch <= 1'b1;
                    if (fail_cnt != CNT_MAX) begin
                        fail_cnt <= fail_cnt + 1'b1;
                    end
                    // Only the first failure is captured; later ones just count.
                    if (state == S_OK) begin
                        fail_info  <= {s1_sub, s1_a, s1_b, s1_c, s1_r, s1_exp};
                        err_sticky <= 1'b1;
                        state      <= S_FAIL;
                    end
                end else if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
